alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//  Multi-cycle MULT/MULTU sequencer that borrows the shared 32-bit ALU to build a 64-bit HI/LO product.
//  Uses iterative shift-add, one ALU ADD per cycle; signed mode negates operands and result through the ALU.
//  Sits beside the EX stage. While alu_sel=1, the EX-stage mux routes alu_a/alu_b/alu_ctrl into the ALU.
//  The pipeline stalls on busy.
// PARAMETERS
//  XLEN    32  operand width; HI and LO are XLEN each
//  CNT_W   5   iteration counter width, clog2(XLEN)
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous, active-low reset
//  start      in   1     request pulse; sampled only in IDLE
//  flush      in   1     pipeline flush; aborts an operation in progress
//  op_signed  in   1     1=MULT (two's complement), 0=MULTU
//  op_a       in   XLEN  multiplicand, sampled with start
//  op_b       in   XLEN  multiplier, sampled with start
//  busy       out  1     operation in progress (every state except IDLE)
//  done       out  1     1-cycle pulse; hi/lo valid
//  hi         out  XLEN  product[63:32]; held until next accepted start
//  lo         out  XLEN  product[31:0]
//  alu_sel    out  1     sequencer owns the ALU
//  alu_a      out  XLEN  ALU Rdata1 drive
//  alu_b      out  XLEN  ALU Mdata drive
//  alu_ctrl   out  4     ALU op: AND=0000 OR=0001 ADD=0010 SUB=0110 SLT=0111 XOR=1100
//  alu_out    in   XLEN  ALU result
//  alu_ovf    in   1     ALU ovf; on ADD it is unsigned carry-out (a > sum)
//  alu_zero   in   1     ALU zero flag (alu_out==0)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, done, alu_sel = 0; hi, lo, alu_a, alu_b = 0; alu_ctrl=0000.
//  States: IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI_INV, NEG_HI_INC, DONE.
//  IDLE, start=1: latch A=op_a, lo=op_b, hi=0, cnt=0, neg_res=op_signed&(op_a[31]^op_b[31]).
//   Next state: NEG_A if op_signed&op_a[31]; else NEG_B if op_signed&op_b[31]; else ITER.
//  NEG_A: ALU 0-A (SUB) -> A. Next: NEG_B if the B sign applies, else ITER.
//  NEG_B: ALU 0-lo (SUB) -> lo. Next: ITER.
//  ITER: alu_a=hi, alu_b=lo[0]?A:0, ctrl=ADD.
//   {hi,lo} <= {alu_ovf, alu_out, lo[XLEN-1:1]}; cnt++.
//   Leaves after the XLEN-th iteration (cnt==XLEN-1): to NEG_LO if neg_res, else to DONE.
//  NEG_LO: ALU 0-lo (SUB) -> lo; lo_zero <= alu_zero.
//  NEG_HI_INV: ALU hi XOR all-ones -> hi. Next: NEG_HI_INC if lo_zero, else DONE.
//  NEG_HI_INC: ALU hi+1 (ADD) -> hi. Next: DONE.
//  DONE: done=1 for exactly one cycle. Next: IDLE; a start is first accepted the cycle after DONE.
//  alu_sel=1 in NEG_*, ITER, NEG_HI_*. alu_a/alu_b/alu_ctrl are combinational from state, and 0 when alu_sel=0.
//  Latency: start sampled at edge 0 gives done in cycle 33 (MULTU).
//   Signed: +1 per negative operand; +2 for result fix (NEG_LO, NEG_HI_INV); +1 more if lo==0 (NEG_HI_INC).
//  busy=1 in every state except IDLE, including DONE; start while busy is ignored, not queued.
//  flush=1 in any state except IDLE: next state IDLE, no done pulse; hi/lo keep partial values (undefined to SW).
//  flush and start together in IDLE: start wins.
//  All arithmetic is modulo 2^XLEN. The carry on the ITER ADD is taken only from alu_ovf, never recomputed locally.
//  0x80000000 in signed mode: 0-x = x, and the unsigned iteration still yields the correct magnitude.
// STRUCTURE
//  mips_alu_pkg holds the ALU_AND/OR/ADD/SUB/SLT/XOR ctrl constants and the mul_state_t encoding.
//  Single module, no sub-module; the ALU stays instantiated in EX and shared via alu_sel.
// TESTING
//  MULTU 3*5 -> done at cycle 33; hi=0, lo=0x0000000F; alu_sel=1 in cycles 1..32 only.
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (exercises alu_ovf carry).
//  MULT -1*-1 -> done at cycle 35; hi=0, lo=1. MULT -2*3 -> cycle 36; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  MULT 0x80000000*2 -> cycle 37 (NEG_HI_INC taken); hi=0xFFFFFFFF, lo=0x00000000.
//  flush at cycle 10 of MULTU 7*9 -> IDLE at cycle 11, no done. A new start 7*9 -> lo=63.
//  Start pulses during busy are ignored, and the result is unchanged.
//  rst_n low at cycle 20 -> all outputs 0 immediately.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared ALU control encodings and the MULT/MULTU sequencer state encoding.
package mips_alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_NEG_A      = 3'd1,
    S_NEG_B      = 3'd2,
    S_ITER       = 3'd3,
    S_NEG_LO     = 3'd4,
    S_NEG_HI_INV = 3'd5,
    S_NEG_HI_INC = 3'd6,
    S_DONE       = 3'd7
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle MULT/MULTU sequencer: shift-add through the shared EX-stage ALU,
// with sign fix-up of operands and the 64-bit HI/LO result done as ALU ops.
module alu_mul_seq
  import mips_alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic            op_signed,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            alu_sel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_ovf,
  input  logic            alu_zero
);

  mul_state_t        state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_b_q, neg_b_d;
  logic              lo_zero_q, lo_zero_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_b_q   <= 1'b0;
      lo_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_b_q   <= neg_b_d;
      lo_zero_q <= lo_zero_d;
    end
  end

  // Next state, datapath updates and ALU drive; ALU ports idle at zero unless owned.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_b_d   = neg_b_q;
    lo_zero_d = lo_zero_q;
    alu_sel   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = ALU_AND;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = op_a;
          lo_d      = op_b;
          hi_d      = '0;
          cnt_d     = '0;
          neg_res_d = op_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
          neg_b_d   = op_signed & op_b[XLEN-1];
          if (op_signed && op_a[XLEN-1])      state_d = S_NEG_A;
          else if (op_signed && op_b[XLEN-1]) state_d = S_NEG_B;
          else                                state_d = S_ITER;
        end
      end
      S_NEG_A: begin
        alu_sel  = 1'b1;
        alu_b    = a_q;
        alu_ctrl = ALU_SUB;
        a_d      = alu_out;
        state_d  = neg_b_q ? S_NEG_B : S_ITER;
      end
      S_NEG_B: begin
        alu_sel  = 1'b1;
        alu_b    = lo_q;
        alu_ctrl = ALU_SUB;
        lo_d     = alu_out;
        state_d  = S_ITER;
      end
      S_ITER: begin
        // Carry into HI comes only from the ALU's carry-out.
        alu_sel      = 1'b1;
        alu_a        = hi_q;
        alu_b        = lo_q[0] ? a_q : '0;
        alu_ctrl     = ALU_ADD;
        {hi_d, lo_d} = {alu_ovf, alu_out, lo_q[XLEN-1:1]};
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = neg_res_q ? S_NEG_LO : S_DONE;
      end
      S_NEG_LO: begin
        alu_sel   = 1'b1;
        alu_b     = lo_q;
        alu_ctrl  = ALU_SUB;
        lo_d      = alu_out;
        lo_zero_d = alu_zero;
        state_d   = S_NEG_HI_INV;
      end
      S_NEG_HI_INV: begin
        // Borrow from LO into HI only when negated LO is zero.
        alu_sel  = 1'b1;
        alu_a    = hi_q;
        alu_b    = '1;
        alu_ctrl = ALU_XOR;
        hi_d     = alu_out;
        state_d  = lo_zero_q ? S_NEG_HI_INC : S_DONE;
      end
      S_NEG_HI_INC: begin
        alu_sel  = 1'b1;
        alu_a    = hi_q;
        alu_b    = XLEN'(1);
        alu_ctrl = ALU_ADD;
        hi_d     = alu_out;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural model of the shared EX ALU.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush, op_signed;
  logic [31:0] op_a, op_b;
  logic        busy, done, alu_sel;
  logic [31:0] hi, lo, alu_a, alu_b, alu_out;
  logic [3:0]  alu_ctrl;
  logic        alu_ovf, alu_zero;

  alu_mul_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op_signed(op_signed),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_ovf(alu_ovf), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // EX-stage ALU model: ovf on ADD is unsigned carry-out.
  logic [32:0] sum33;
  always_comb begin
    sum33   = {1'b0, alu_a} + {1'b0, alu_b};
    alu_out = 32'h0;
    alu_ovf = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: begin alu_out = sum33[31:0]; alu_ovf = sum33[32]; end
      4'b0110: alu_out = alu_a - alu_b;
      4'b0111: alu_out = {31'h0, $signed(alu_a) < $signed(alu_b)};
      4'b1100: alu_out = alu_a ^ alu_b;
      default: alu_out = 32'h0;
    endcase
    alu_zero = (alu_out == 32'h0);
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          edge0;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   sel_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts ALU-ownership cycles and checks each done pulse against the queue.
  always @(negedge clk) begin
    if (!busy) sel_cnt = 0;
    else if (alu_sel) sel_cnt++;
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("latency", 64'(cyc - e.edge0 + 1), 64'(e.lat));
        chk("alu_sel_cycles", 64'(sel_cnt), 64'(e.lat - 1));
        chk("alu_sel_in_done", 64'(alu_sel), 64'(0));
        chk("busy_in_done", 64'(busy), 64'(1));
      end
    end
  end

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int lat,
                        input bit poke);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(negedge clk);
    e.hi = eh; e.lo = el; e.lat = lat; e.edge0 = cyc + 1;
    q.push_back(e);
    op_signed = s; op_a = a; op_b = b; start = 1'b1;
    for (int i = 1; i < 60; i++) begin
      @(negedge clk);
      start = poke && (i == 4 || i == 11);
      op_a  = $urandom;
      op_b  = $urandom;
      if (done) begin got = 1'b1; break; end
    end
    start = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no done for a=0x%0h b=0x%0h", a, b);
      q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op_signed = 1'b0; op_a = '0; op_b = '0;
    #1;
    chk("reset_ctrl", 64'({busy, done, alu_sel, alu_ctrl}), 64'(0));
    chk("reset_hilo", {hi, lo}, 64'(0));
    chk("reset_alu_ab", {alu_a, alu_b}, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 32'd3,        32'd5,        32'h0,        32'h0000000F, 33, 1'b0);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0);
    run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h00000001, 35, 1'b0);
    run_op(1'b1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 36, 1'b0);
    run_op(1'b1, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000, 37, 1'b0);
    run_op(1'b1, 32'd5,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1, 36, 1'b0);
    run_op(1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 35, 1'b0);
    run_op(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 1'b0);
    run_op(1'b0, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        33, 1'b0);
    run_op(1'b1, 32'd7,        32'd6,        32'h0,        32'd42,       33, 1'b0);
    run_op(1'b0, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 33, 1'b1);

    // Flush in cycle 10 of MULTU 7*9: idle in cycle 11, no done afterwards.
    @(negedge clk);
    op_signed = 1'b0; op_a = 32'd7; op_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_before_flush", 64'(busy), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("busy_after_flush", 64'(busy), 64'(0));
    chk("alu_sel_after_flush", 64'(alu_sel), 64'(0));
    repeat (40) @(negedge clk);
    run_op(1'b0, 32'd7, 32'd9, 32'h0, 32'd63, 33, 1'b0);

    // Asynchronous reset in cycle 20 of an operation.
    @(negedge clk);
    op_signed = 1'b0; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("busy_before_reset", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", 64'({busy, done, alu_sel, alu_ctrl}), 64'(0));
    chk("async_reset_hilo", {hi, lo}, 64'(0));
    chk("async_reset_alu_ab", {alu_a, alu_b}, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("busy_idle_after_reset", 64'(busy), 64'(0));
    chk("scoreboard_drained", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
